// File: rtl/imm_ext_pipe.sv
// Immediate generator between Decode and Execute: decodes the selected format,
// then registers it behind a valid/ready handshake with a one-entry skid buffer.
module imm_ext_pipe #(
    parameter int XLEN           = 64,
    parameter int ZERO_OFFSET_EN = 1,
    parameter int SHAMT_EN       = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [24:0]     InstrD,
    input  logic [2:0]      ImmSrcD,
    input  logic            ValidD,
    output logic            ReadyD,
    input  logic            FlushE,
    output logic [XLEN-1:0] ImmExtE,
    output logic            IllegalImmE,
    output logic            ValidE,
    input  logic            ReadyE
);

    // InstrD carries instruction bits [31:7]; keep the architectural numbering.
    logic [31:7] instr;
    assign instr = InstrD;

    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    always_comb begin
        dec_imm = '0;
        dec_ill = 1'b0;
        case (ImmSrcD)
            3'b000: dec_imm = XLEN'($signed(instr[31:20]));
            3'b001: dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            3'b010: dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                              instr[11:8], 1'b0}));
            3'b011: dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                              instr[30:21], 1'b0}));
            3'b100: dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
            3'b101: dec_ill = (ZERO_OFFSET_EN == 0);
            3'b110: dec_imm = XLEN'(instr[19:15]);
            3'b111: begin
                if (SHAMT_EN == 0)  dec_ill = 1'b1;
                else if (XLEN == 64) dec_imm = XLEN'(instr[25:20]);
                else                dec_imm = XLEN'(instr[24:20]);
            end
            default: begin
                dec_imm = '0;
                dec_ill = 1'b1;
            end
        endcase
    end

    logic            valid_q, valid_d;
    logic [XLEN-1:0] ext_q, ext_d;
    logic            ill_q, ill_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_ext_q, skid_ext_d;
    logic            skid_ill_q, skid_ill_d;
    logic            accept;

    assign ReadyD = !skid_valid_q;
    assign accept = ValidD & ReadyD;

    always_comb begin
        valid_d      = valid_q;
        ext_d        = ext_q;
        ill_d        = ill_q;
        skid_valid_d = skid_valid_q;
        skid_ext_d   = skid_ext_q;
        skid_ill_d   = skid_ill_q;
        // Flush only clears valid bits; data registers keep their contents.
        if (FlushE) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!valid_q || ReadyE) begin
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                ext_d        = skid_ext_q;
                ill_d        = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                valid_d = 1'b1;
                ext_d   = dec_imm;
                ill_d   = dec_ill;
            end else begin
                valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ext_d   = dec_imm;
            skid_ill_d   = dec_ill;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= 1'b0;
            ext_q        <= '0;
            ill_q        <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_ext_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            ext_q        <= ext_d;
            ill_q        <= ill_d;
            skid_valid_q <= skid_valid_d;
            skid_ext_q   <= skid_ext_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign ValidE      = valid_q;
    assign ImmExtE     = ext_q;
    assign IllegalImmE = ill_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: three builds (64-bit, 32-bit, optional formats off)
// share one stimulus stream; a scoreboard checks every delivered output in order.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [24:0] InstrD = '0;
    logic [2:0]  ImmSrcD = '0;
    logic        ValidD = 1'b0;
    logic        FlushE = 1'b0;
    logic        ReadyE = 1'b0;

    logic        ReadyD, IllegalImmE, ValidE;
    logic [63:0] ImmExtE;
    logic        ReadyD32, Ill32, Valid32;
    logic [31:0] ImmExt32;
    logic        ReadyDNs, IllNs, ValidNs;
    logic [63:0] ImmExtNs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(64)) dut (
        .clk(clk), .reset_n(reset_n), .InstrD(InstrD), .ImmSrcD(ImmSrcD),
        .ValidD(ValidD), .ReadyD(ReadyD), .FlushE(FlushE), .ImmExtE(ImmExtE),
        .IllegalImmE(IllegalImmE), .ValidE(ValidE), .ReadyE(ReadyE));

    imm_ext_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .InstrD(InstrD), .ImmSrcD(ImmSrcD),
        .ValidD(ValidD), .ReadyD(ReadyD32), .FlushE(FlushE), .ImmExtE(ImmExt32),
        .IllegalImmE(Ill32), .ValidE(Valid32), .ReadyE(ReadyE));

    imm_ext_pipe #(.XLEN(64), .ZERO_OFFSET_EN(0), .SHAMT_EN(0)) dutns (
        .clk(clk), .reset_n(reset_n), .InstrD(InstrD), .ImmSrcD(ImmSrcD),
        .ValidD(ValidD), .ReadyD(ReadyDNs), .FlushE(FlushE), .ImmExtE(ImmExtNs),
        .IllegalImmE(IllNs), .ValidE(ValidNs), .ReadyE(ReadyE));

    typedef struct {
        logic [63:0] e64; logic i64;
        logic [63:0] e32; logic i32;
        logic [63:0] ens; logic ins;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the format table; {ill, imm}.
    function automatic logic [64:0] model(input logic [31:0] ins, input logic [2:0] src,
                                          input int xlen, input bit zo, input bit sh);
        logic [63:0] r;
        logic        ill;
        r = '0;
        ill = 1'b0;
        case (src)
            3'd0: r = {{52{ins[31]}}, ins[31:20]};
            3'd1: r = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2: r = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3: r = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd4: r = {{32{ins[31]}}, ins[31:12], 12'b0};
            3'd5: ill = !zo;
            3'd6: r = {59'b0, ins[19:15]};
            default: begin
                if (!sh)             ill = 1'b1;
                else if (xlen == 64) r = {58'b0, ins[25:20]};
                else                 r = {59'b0, ins[24:20]};
            end
        endcase
        if (xlen == 32) r[63:32] = '0;
        return {ill, r};
    endfunction

    function automatic exp_t mk(input logic [31:0] ins, input logic [2:0] src);
        exp_t e;
        logic [64:0] m;
        m = model(ins, src, 64, 1'b1, 1'b1); e.e64 = m[63:0]; e.i64 = m[64];
        m = model(ins, src, 32, 1'b1, 1'b1); e.e32 = m[63:0]; e.i32 = m[64];
        m = model(ins, src, 64, 1'b0, 1'b0); e.ens = m[63:0]; e.ins = m[64];
        return e;
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm);
        return {imm, 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    logic        held = 1'b0;
    logic [63:0] held_imm = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (held && ValidE) chk("hold_stable", ImmExtE, held_imm);
            if (FlushE) begin
                q.delete();
            end else begin
                if (ValidE && ReadyE) begin
                    chk("sb_has_entry", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("sb_imm64", ImmExtE, e.e64);
                        chk("sb_ill64", IllegalImmE, e.i64);
                        chk("sb_v32", Valid32, 1'b1);
                        chk("sb_imm32", ImmExt32, e.e32);
                        chk("sb_ill32", Ill32, e.i32);
                        chk("sb_vns", ValidNs, 1'b1);
                        chk("sb_immns", ImmExtNs, e.ens);
                        chk("sb_illns", IllNs, e.ins);
                    end
                end
                if (ValidD && ReadyD) q.push_back(mk({InstrD, 7'b0}, ImmSrcD));
            end
            held = ValidE && !ReadyE && !FlushE;
            held_imm = ImmExtE;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chk(input string tag, input logic [31:0] inst, input logic [2:0] src,
                            input logic [63:0] e64, input logic i64, input logic [31:0] e32,
                            input logic [63:0] ens, input logic ins_ill);
        ValidD = 1'b1;
        InstrD = inst[31:7];
        ImmSrcD = src;
        step();
        chk({tag, "_v"}, ValidE, 1'b1);
        chk(tag, ImmExtE, e64);
        chk({tag, "_ill"}, IllegalImmE, i64);
        chk({tag, "_32"}, ImmExt32, e32);
        chk({tag, "_ns"}, ImmExtNs, ens);
        chk({tag, "_nsill"}, IllNs, ins_ill);
    endtask

    task automatic drive_i(input logic [11:0] imm);
        logic [31:0] w;
        w = i_ins(imm);
        ValidD = 1'b1;
        InstrD = w[31:7];
        ImmSrcD = 3'd0;
    endtask

    initial begin
        #12;
        chk("rst_valid", ValidE, 1'b0);
        chk("rst_imm", ImmExtE, 64'd0);
        chk("rst_ill", IllegalImmE, 1'b0);
        chk("rst_valid32", Valid32, 1'b0);
        reset_n = 1'b1;
        #1;
        chk("rst_readyd", ReadyD, 1'b1);
        step();

        ReadyE = 1'b1;
        send_chk("i_neg1", 32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        // beq x0,x0,-4
        send_chk("b_m4", 32'hFE000EE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0,
                 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send_chk("u_neg", 32'h800000B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0,
                 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send_chk("csr_1f", 32'h000F8073, 3'd6, 64'h1F, 1'b0, 32'h1F, 64'h1F, 1'b0);
        send_chk("shamt", 32'h03F00013, 3'd7, 64'h3F, 1'b0, 32'h1F, 64'h0, 1'b1);
        send_chk("zero", 32'hFFFFA02F, 3'd5, 64'h0, 1'b0, 32'h0, 64'h0, 1'b1);
        send_chk("s_m8", 32'hFE000C23, 3'd1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0,
                 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        send_chk("j_2048", 32'h0010006F, 3'd3, 64'h800, 1'b0, 32'h800, 64'h800, 1'b0);
        send_chk("i_7ff", 32'h7FF00013, 3'd0, 64'h7FF, 1'b0, 32'h7FF, 64'h7FF, 1'b0);
        ValidD = 1'b0;
        step();
        chk("idle_valid", ValidE, 1'b0);

        // Backpressure: A, B captured, C held off until space frees.
        ReadyE = 1'b0;
        drive_i(12'd5); step();
        chk("bp_a_valid", ValidE, 1'b1);
        chk("bp_a_imm", ImmExtE, 64'd5);
        chk("bp_a_ready", ReadyD, 1'b1);
        drive_i(12'd6); step();
        chk("bp_b_full", ReadyD, 1'b0);
        drive_i(12'd7); step();
        chk("bp_c_full", ReadyD, 1'b0);
        chk("bp_c_hold", ImmExtE, 64'd5);
        ReadyE = 1'b1; step();
        chk("bp_out_b", ImmExtE, 64'd6);
        chk("bp_ready_back", ReadyD, 1'b1);
        step();
        chk("bp_out_c", ImmExtE, 64'd7);
        ValidD = 1'b0; step();
        chk("bp_drained", ValidE, 1'b0);

        // Flush with both entries held.
        ReadyE = 1'b0;
        drive_i(12'h11); step();
        drive_i(12'h22); step();
        chk("fl_full", ReadyD, 1'b0);
        FlushE = 1'b1; drive_i(12'h33); step();
        FlushE = 1'b0; ValidD = 1'b0;
        chk("fl_valid", ValidE, 1'b0);
        chk("fl_ready", ReadyD, 1'b1);
        chk("fl_data_kept", ImmExtE, 64'h11);
        ReadyE = 1'b1; step();
        chk("fl_no_deliver", ValidE, 1'b0);
        drive_i(12'h44); step();
        chk("fl_next_v", ValidE, 1'b1);
        chk("fl_next_imm", ImmExtE, 64'h44);
        ValidD = 1'b0; step();

        // Flush beats a same-cycle accept.
        ReadyE = 1'b0;
        drive_i(12'h55); step();
        FlushE = 1'b1; drive_i(12'h66); step();
        FlushE = 1'b0; ValidD = 1'b0;
        chk("fl2_valid", ValidE, 1'b0);
        ReadyE = 1'b1; step();
        chk("fl2_dropped", ValidE, 1'b0);

        // Asynchronous reset mid-cycle.
        ReadyE = 1'b0;
        drive_i(12'h77); step();
        ValidD = 1'b0;
        chk("ar_pre_valid", ValidE, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", ValidE, 1'b0);
        chk("ar_imm", ImmExtE, 64'd0);
        chk("ar_ready", ReadyD, 1'b1);
        @(negedge clk);
        #2 reset_n = 1'b1;
        step();
        chk("ar_after", ValidE, 1'b0);
        ReadyE = 1'b1;
        drive_i(12'h12); step();
        chk("ar_resume", ImmExtE, 64'h12);
        ValidD = 1'b0;
        repeat (3) step();
        chk("sb_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
